pair_borrow_subtractor: RTL and testbench

Digit-serial unsigned subtractor that computes `diff = a - b - bin` two bits per clock. Each 2-bit digit uses a lookahead borrow, the subtraction counterpart of the 2-bit carry-lookahead used on the adder path. It sits beside the adders in the arithmetic datapath. Operands are accepted through a valid/ready handshake and the result is returned through a second valid/ready handshake. Area stays small because only one 2-bit slice is instantiated and it is reused for `WIDTH/2` cycles.

---
 rtl/pair_borrow_subtractor.sv | 106 ++++++++++
 tb/tb_pair_borrow_subtractor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pair_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : pair_borrow_subtractor
// Description : Digit-serial unsigned subtractor, diff = a - b - bin, two bits
//               per clock through one reused 2-bit lookahead-borrow slice.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_borrow_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int c_DIGITS = WIDTH / 2;
    localparam int c_KW     = (c_DIGITS > 1) ? $clog2(c_DIGITS) : 1;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(c_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [c_KW-1:0]  r_k;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [1:0] w_x;
    logic [1:0] w_y;
    logic [1:0] w_g;
    logic [1:0] w_p;
    logic       w_br;
    logic [1:0] w_digit;

    // The latched operands shift down two bits per digit, so the slice
    // always works on the low pair.
    assign w_x     = r_a[1:0];
    assign w_y     = r_b[1:0];
    assign w_g     = ~w_x & w_y;
    assign w_p     = ~(w_x ^ w_y);
    assign w_br    = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    assign w_digit = w_x - w_y - {1'b0, r_borrow};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_k      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_k      <= '0;
                        r_diff   <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_diff[{r_k, 1'b0} +: 2] <= w_digit;
                    r_borrow <= w_br;
                    r_a      <= r_a >> 2;
                    r_b      <= r_b >> 2;
                    r_k      <= r_k + 1'b1;
                    if (r_k == c_LAST) begin
                        r_bout  <= w_br;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == IDLE) & ~reset;
    assign done_valid  = (r_state == DONE);
    assign diff        = r_diff;
    assign bout        = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_pair_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pair_borrow_subtractor
// Description : Directed and random checks of pair_borrow_subtractor (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_borrow_subtractor;

    localparam int c_WIDTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_valid;
    logic               start_ready;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] b;
    logic               bin;
    logic               done_valid;
    logic               done_ready;
    logic [c_WIDTH-1:0] diff;
    logic               bout;

    int n_checks = 0;
    int n_fail   = 0;

    pair_borrow_subtractor #(.WIDTH(c_WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .bin         (bin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .diff        (diff),
        .bout        (bout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         output logic [7:0] ediff, output logic ebout);
        int d;
        d     = int'(ta) - int'(tb) - int'(tbin);
        ebout = (d < 0);
        ediff = 8'((d + 256) % 256);
    endtask

    // Accepts one operation and waits for done_valid. With poke set, new
    // operands are offered while the block is busy.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input bit poke, input string tag);
        int         cyc;
        logic [7:0] ediff;
        logic       ebout;
        model(ta, tb, tbin, ediff, ebout);
        check({tag, "_start_ready"}, start_ready, 1);
        a = ta; b = tb; bin = tbin; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        cyc = 0;
        while (!done_valid && cyc < 20) begin
            if (poke) begin
                start_valid = 1'b1;
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
                check({tag, "_busy_ready"}, start_ready, 0);
            end
            step();
            cyc++;
        end
        start_valid = 1'b0;
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_diff"}, diff, ediff);
        check({tag, "_bout"}, bout, ebout);
    endtask

    task automatic release_done(input string tag);
        done_ready = 1'b1;
        step();
        check({tag, "_done_drop"}, done_valid, 0);
        check({tag, "_ready_back"}, start_ready, 1);
    endtask

    initial begin
        logic [7:0] hold_diff;
        logic       hold_bout;
        logic [7:0] ra, rb;
        logic       rbin;

        reset = 1'b1; start_valid = 1'b0; done_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;

        // Reset held three cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            start_valid = 1'($urandom); done_ready = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            step();
            check("rst_diff", diff, 0);
            check("rst_bout", bout, 0);
            check("rst_done_valid", done_valid, 0);
            check("rst_start_ready", start_ready, 0);
        end
        start_valid = 1'b0; done_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", start_ready, 1);

        launch(8'h5A, 8'h3C, 1'b0, 1'b0, "basic");
        check("basic_const_diff", diff, 8'h1E);
        release_done("basic");

        launch(8'h00, 8'h01, 1'b0, 1'b0, "ripple");
        check("ripple_const_diff", diff, 8'hFF);
        check("ripple_const_bout", bout, 1);
        release_done("ripple");

        launch(8'h80, 8'h7F, 1'b1, 1'b0, "bin_a");
        release_done("bin_a");
        launch(8'h7F, 8'h7F, 1'b1, 1'b0, "bin_b");
        release_done("bin_b");

        // Result must persist in IDLE.
        step();
        check("idle_hold_diff", diff, 8'hFF);
        check("idle_hold_bout", bout, 1);

        // Backpressure with start_valid pokes during RUN and DONE.
        done_ready = 1'b0;
        launch(8'hC3, 8'h5D, 1'b1, 1'b1, "bp");
        hold_diff = diff;
        hold_bout = bout;
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            check("bp_busy_ready", start_ready, 0);
            step();
            check("bp_done_valid", done_valid, 1);
            check("bp_diff_stable", diff, hold_diff);
            check("bp_bout_stable", bout, hold_bout);
        end
        start_valid = 1'b0;
        release_done("bp");

        // Reset at edge E2 of an operation.
        a = 8'h12; b = 8'h34; bin = 1'b0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("midrst_diff", diff, 0);
        check("midrst_done_valid", done_valid, 0);
        check("midrst_start_ready", start_ready, 0);
        reset = 1'b0;
        #1;
        check("midrst_ready_back", start_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_done", done_valid, 0);
        end
        launch(8'hFF, 8'h01, 1'b0, 1'b0, "after_rst");
        check("after_rst_const", diff, 8'hFE);
        release_done("after_rst");

        // Random operations against the reference model.
        for (int i = 0; i < 12; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            launch(ra, rb, rbin, 1'b0, "rand");
            release_done("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
